// File: rtl/axil_arbiter_rr_rd.sv
// AXI-Lite read-path arbiter: grants one master at a time across AR and R phases.
// Fixed-priority or round-robin selection, with a per-phase watchdog.
module axil_arbiter_rr_rd #(
  parameter int NUMBER_MASTER  = 4,
  parameter int ARB_MODE       = 1,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int W = $clog2(NUMBER_MASTER)
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [NUMBER_MASTER-1:0] request_rd,
  input  logic [NUMBER_MASTER-1:0] m_axil_arvalid,
  input  logic                     s_axil_arready,
  input  logic                     s_axil_rvalid,
  input  logic [NUMBER_MASTER-1:0] m_axil_rready,
  output logic [NUMBER_MASTER-1:0] grant_rd,
  output logic [W-1:0]             grant_idx,
  output logic                     grant_valid,
  output logic                     timeout_err,
  output logic [W-1:0]             timeout_idx
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TO_LIM =
    WD_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

  state_t       state;
  logic [W-1:0] last_idx;
  logic [W-1:0] win_idx;
  logic [15:0]  wd_cnt;
  logic         ar_hs;
  logic         r_hs;
  logic         wd_exp;

  // Later loop iterations overwrite earlier ones, so the last hit is the
  // highest-priority candidate in both modes.
  always_comb begin
    int j;
    j       = 0;
    win_idx = '0;
    if (ARB_MODE == 0) begin
      for (int i = NUMBER_MASTER - 1; i >= 0; i--) begin
        if (request_rd[i]) win_idx = W'(i);
      end
    end else begin
      for (int k = NUMBER_MASTER; k >= 1; k--) begin
        j = (int'(last_idx) + k) % NUMBER_MASTER;
        if (request_rd[j[W-1:0]]) win_idx = j[W-1:0];
      end
    end
  end

  assign ar_hs  = m_axil_arvalid[grant_idx] && s_axil_arready;
  assign r_hs   = s_axil_rvalid && m_axil_rready[grant_idx];
  assign wd_exp = WD_EN && (wd_cnt >= TO_LIM);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state       <= IDLE;
      grant_rd    <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      timeout_err <= 1'b0;
      timeout_idx <= '0;
      wd_cnt      <= '0;
      last_idx    <= W'(NUMBER_MASTER - 1);
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (|request_rd) begin
            grant_rd    <= NUMBER_MASTER'(1) << win_idx;
            grant_idx   <= win_idx;
            grant_valid <= 1'b1;
            last_idx    <= win_idx;
            wd_cnt      <= '0;
            state       <= ADDR;
          end
        end
        ADDR, DATA: begin
          if ((state == ADDR) && ar_hs) begin
            wd_cnt <= '0;
            state  <= DATA;
          end else if ((state == DATA) && r_hs) begin
            grant_rd    <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            wd_cnt      <= '0;
            state       <= IDLE;
          end else if (wd_exp) begin
            // last_idx keeps the stalled master so it drops to lowest priority
            timeout_err <= 1'b1;
            timeout_idx <= grant_idx;
            grant_rd    <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            wd_cnt      <= '0;
            state       <= IDLE;
          end else if (wd_cnt != 16'hFFFF) begin
            wd_cnt <= wd_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_arbiter_rr_rd.sv
// Directed bench: table of per-cycle vectors plus hand sequences
// for watchdog expiry, last-cycle completion and mid-transaction reset.
module tb_axil_arbiter_rr_rd;

  logic       aclk;
  logic       aresetn;
  logic [3:0] request_rd;
  logic [3:0] m_axil_arvalid;
  logic       s_axil_arready;
  logic       s_axil_rvalid;
  logic [3:0] m_axil_rready;

  logic [3:0] g_rr, g_fx;
  logic [1:0] gi_rr, gi_fx;
  logic       gv_rr, gv_fx;
  logic       te_rr, te_fx;
  logic [1:0] ti_rr, ti_fx;

  int checks = 0;
  int errors = 0;

  axil_arbiter_rr_rd #(
    .NUMBER_MASTER (4),
    .ARB_MODE      (1),
    .TIMEOUT_CYCLES(8)
  ) u_rr (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .request_rd    (request_rd),
    .m_axil_arvalid(m_axil_arvalid),
    .s_axil_arready(s_axil_arready),
    .s_axil_rvalid (s_axil_rvalid),
    .m_axil_rready (m_axil_rready),
    .grant_rd      (g_rr),
    .grant_idx     (gi_rr),
    .grant_valid   (gv_rr),
    .timeout_err   (te_rr),
    .timeout_idx   (ti_rr)
  );

  axil_arbiter_rr_rd #(
    .NUMBER_MASTER (4),
    .ARB_MODE      (0),
    .TIMEOUT_CYCLES(0)
  ) u_fx (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .request_rd    (request_rd),
    .m_axil_arvalid(m_axil_arvalid),
    .s_axil_arready(s_axil_arready),
    .s_axil_rvalid (s_axil_rvalid),
    .m_axil_rready (m_axil_rready),
    .grant_rd      (g_fx),
    .grant_idx     (gi_fx),
    .grant_valid   (gv_fx),
    .timeout_err   (te_fx),
    .timeout_idx   (ti_fx)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic       rst_n;
    logic       fx;
    logic [3:0] req;
    logic [3:0] arv;
    logic       ard;
    logic       rv;
    logic [3:0] rrd;
    logic [3:0] g;
    logic [1:0] gi;
    logic       gv;
    logic       te;
    logic [1:0] ti;
  } vec_t;

  vec_t vq[$];

  task automatic add(
    input logic rst_n, input logic fx,
    input logic [3:0] req, input logic [3:0] arv,
    input logic ard, input logic rv, input logic [3:0] rrd,
    input logic [3:0] g, input logic [1:0] gi,
    input logic gv, input logic te, input logic [1:0] ti);
    vec_t v;
    v.rst_n = rst_n; v.fx = fx; v.req = req; v.arv = arv;
    v.ard = ard; v.rv = rv; v.rrd = rrd; v.g = g;
    v.gi = gi; v.gv = gv; v.te = te; v.ti = ti;
    vq.push_back(v);
  endtask

  function automatic logic [31:0] pk_rr();
    return 32'({g_rr, gi_rr, gv_rr, te_rr, ti_rr});
  endfunction

  function automatic logic [31:0] pk_fx();
    return 32'({g_fx, gi_fx, gv_fx, te_fx, ti_fx});
  endfunction

  function automatic logic [31:0] pk(
    input logic [3:0] g, input logic [1:0] gi,
    input logic gv, input logic te, input logic [1:0] ti);
    return 32'({g, gi, gv, te, ti});
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got {g,gi,gv,te,ti}=%h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst_n, input logic [3:0] req,
                       input logic [3:0] arv, input logic ard,
                       input logic rv, input logic [3:0] rrd);
    aresetn        = rst_n;
    request_rd     = req;
    m_axil_arvalid = arv;
    s_axil_arready = ard;
    s_axil_rvalid  = rv;
    m_axil_rready  = rrd;
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0);
    tick();
  endtask

  initial begin
    drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0);

    // round-robin, all requesting, single-cycle handshakes
    add(0,0, 4'hF,4'hF,1,1,4'hF, 4'b0000,2'd0,0,0,2'd0);
    add(1,0, 4'hF,4'hF,1,1,4'hF, 4'b0001,2'd0,1,0,2'd0);
    add(1,0, 4'hF,4'hF,1,1,4'hF, 4'b0001,2'd0,1,0,2'd0);
    add(1,0, 4'hF,4'hF,1,1,4'hF, 4'b0000,2'd0,0,0,2'd0);
    add(1,0, 4'hF,4'hF,1,1,4'hF, 4'b0010,2'd1,1,0,2'd0);
    add(1,0, 4'hF,4'hF,1,1,4'hF, 4'b0010,2'd1,1,0,2'd0);
    add(1,0, 4'hF,4'hF,1,1,4'hF, 4'b0000,2'd0,0,0,2'd0);
    add(1,0, 4'hF,4'hF,1,1,4'hF, 4'b0100,2'd2,1,0,2'd0);
    add(1,0, 4'hF,4'hF,1,1,4'hF, 4'b0100,2'd2,1,0,2'd0);
    add(1,0, 4'hF,4'hF,1,1,4'hF, 4'b0000,2'd0,0,0,2'd0);
    add(1,0, 4'hF,4'hF,1,1,4'hF, 4'b1000,2'd3,1,0,2'd0);
    add(1,0, 4'hF,4'hF,1,1,4'hF, 4'b1000,2'd3,1,0,2'd0);
    add(1,0, 4'hF,4'hF,1,1,4'hF, 4'b0000,2'd0,0,0,2'd0);
    add(1,0, 4'hF,4'hF,1,1,4'hF, 4'b0001,2'd0,1,0,2'd0);
    // fixed priority, 1010 held: master 1 every time
    add(0,1, 4'hA,4'hF,1,1,4'hF, 4'b0000,2'd0,0,0,2'd0);
    for (int r = 0; r < 3; r++) begin
      add(1,1, 4'hA,4'hF,1,1,4'hF, 4'b0010,2'd1,1,0,2'd0);
      add(1,1, 4'hA,4'hF,1,1,4'hF, 4'b0010,2'd1,1,0,2'd0);
      add(1,1, 4'hA,4'hF,1,1,4'hF, 4'b0000,2'd0,0,0,2'd0);
    end
    // grant held in DATA while requests change
    add(0,0, 4'h0,4'h0,0,0,4'h0, 4'b0000,2'd0,0,0,2'd0);
    add(1,0, 4'h4,4'h0,0,0,4'h0, 4'b0100,2'd2,1,0,2'd0);
    add(1,0, 4'h4,4'h4,1,0,4'h0, 4'b0100,2'd2,1,0,2'd0);
    add(1,0, 4'h1,4'h0,0,0,4'h0, 4'b0100,2'd2,1,0,2'd0);
    add(1,0, 4'h1,4'h0,0,0,4'h0, 4'b0100,2'd2,1,0,2'd0);
    add(1,0, 4'h1,4'h0,0,1,4'h3, 4'b0100,2'd2,1,0,2'd0);
    add(1,0, 4'h1,4'h0,0,1,4'h4, 4'b0000,2'd0,0,0,2'd0);
    add(1,0, 4'h1,4'h0,0,0,4'h0, 4'b0001,2'd0,1,0,2'd0);

    foreach (vq[i]) begin
      drive(vq[i].rst_n, vq[i].req, vq[i].arv,
            vq[i].ard, vq[i].rv, vq[i].rrd);
      tick();
      chk($sformatf("vec%0d", i), vq[i].fx ? pk_fx() : pk_rr(),
          pk(vq[i].g, vq[i].gi, vq[i].gv, vq[i].te, vq[i].ti));
    end

    // ADDR watchdog: master 1 stalls, master 2 waits
    do_reset();
    drive(1, 4'b0010, 4'h0, 0, 0, 4'h0);
    tick();
    chk("to_grant", pk_rr(), pk(4'b0010, 2'd1, 1, 0, 2'd0));
    drive(1, 4'b0110, 4'h0, 0, 0, 4'h0);
    for (int k = 2; k <= 8; k++) begin
      tick();
      chk($sformatf("to_hold%0d", k), pk_rr(),
          pk(4'b0010, 2'd1, 1, 0, 2'd0));
    end
    tick();
    chk("to_expire", pk_rr(), pk(4'b0000, 2'd0, 0, 1, 2'd1));
    chk("fx_no_wd", pk_fx(), pk(4'b0010, 2'd1, 1, 0, 2'd0));
    tick();
    chk("to_next_rr", pk_rr(), pk(4'b0100, 2'd2, 1, 0, 2'd1));

    // completion on the last permitted DATA cycle
    do_reset();
    drive(1, 4'b0001, 4'h0, 0, 0, 4'h0);
    tick();
    chk("lc_grant", pk_rr(), pk(4'b0001, 2'd0, 1, 0, 2'd0));
    drive(1, 4'b0001, 4'b0001, 1, 0, 4'h0);
    tick();
    chk("lc_data", pk_rr(), pk(4'b0001, 2'd0, 1, 0, 2'd0));
    drive(1, 4'b0001, 4'h0, 0, 0, 4'h0);
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("lc_wait%0d", k), pk_rr(),
          pk(4'b0001, 2'd0, 1, 0, 2'd0));
    end
    drive(1, 4'b0001, 4'h0, 0, 1, 4'b0001);
    tick();
    chk("lc_done", pk_rr(), pk(4'b0000, 2'd0, 0, 0, 2'd0));
    drive(1, 4'b0001, 4'h0, 0, 0, 4'h0);
    tick();
    chk("lc_regrant", pk_rr(), pk(4'b0001, 2'd0, 1, 0, 2'd0));

    // reset during DATA
    do_reset();
    drive(1, 4'b0010, 4'h0, 0, 0, 4'h0);
    tick();
    chk("rs_grant", pk_rr(), pk(4'b0010, 2'd1, 1, 0, 2'd0));
    drive(1, 4'b0010, 4'b0010, 1, 0, 4'h0);
    tick();
    chk("rs_data", pk_rr(), pk(4'b0010, 2'd1, 1, 0, 2'd0));
    drive(0, 4'b1110, 4'h0, 0, 0, 4'h0);
    tick();
    chk("rs_clear_rr", pk_rr(), pk(4'b0000, 2'd0, 0, 0, 2'd0));
    chk("rs_clear_fx", pk_fx(), pk(4'b0000, 2'd0, 0, 0, 2'd0));
    drive(1, 4'b1110, 4'h0, 0, 0, 4'h0);
    tick();
    chk("rs_first_rr", pk_rr(), pk(4'b0010, 2'd1, 1, 0, 2'd0));
    chk("rs_first_fx", pk_fx(), pk(4'b0010, 2'd1, 1, 0, 2'd0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_arbiter_rr_rd.md
AXIL_ARBITER_RR_RD -- requirements
Module: axil_arbiter_rr_rd

Interface
REQ-001 Parameter NUMBER_MASTER, default 4: number of requesting masters; legal range 2..32.
REQ-002 Parameter ARB_MODE, default 1: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-003 Parameter TIMEOUT_CYCLES, default 256: watchdog limit per phase; 0 disables the watchdog; legal range 0..65535.
REQ-004 aclk  input  1  clock; all logic rising-edge.
REQ-005 aresetn  input  1  reset, synchronous, active-low.
REQ-006 request_rd  input  NUMBER_MASTER  per-master read request.
REQ-007 m_axil_arvalid  input  NUMBER_MASTER  per-master ARVALID.
REQ-008 s_axil_arready  input  1  slave-side ARREADY.
REQ-009 s_axil_rvalid  input  1  slave-side RVALID.
REQ-010 m_axil_rready  input  NUMBER_MASTER  per-master RREADY.
REQ-011 grant_rd  output  NUMBER_MASTER  one-hot grant, registered.
REQ-012 grant_idx  output  W=$clog2(NUMBER_MASTER)  binary index of granted master, registered.
REQ-013 grant_valid  output  1  high while any grant is held.
REQ-014 timeout_err  output  1  one-cycle pulse on watchdog expiry.
REQ-015 timeout_idx  output  W  index of master whose transaction timed out; holds until the next expiry.

Function
REQ-016 The FSM SHALL have states IDLE, ADDR and DATA.
REQ-017 IDLE: if request_rd is nonzero, the block SHALL register the winner into grant_rd/grant_idx, assert grant_valid and go to ADDR on the next edge; otherwise it SHALL stay in IDLE with grant_rd = 0.
REQ-018 ARB_MODE=0: the winner SHALL be the lowest set index of request_rd.
REQ-019 ARB_MODE=1: the winner SHALL be the first set request searching from (last_idx+1) upward, wrapping NUMBER_MASTER-1 -> 0; last_idx SHALL update to the winner at grant time.
REQ-020 ADDR: on m_axil_arvalid[grant_idx] && s_axil_arready, the FSM SHALL go to DATA; R-channel activity in ADDR SHALL be ignored.
REQ-021 DATA: on s_axil_rvalid && m_axil_rready[grant_idx], the FSM SHALL go to IDLE and clear grant_rd, grant_idx and grant_valid on the same edge.
REQ-022 The grant SHALL NOT change while in ADDR or DATA, even if request_rd[grant_idx] deasserts or higher-priority requests arrive.
REQ-023 Minimum spacing: the FSM SHALL spend at least one IDLE cycle between grants; grant-to-grant minimum period is 3 cycles.
REQ-024 The watchdog counter SHALL clear on entry to ADDR and on entry to DATA, and increment every cycle spent in ADDR or DATA.
REQ-025 If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES-1 without the phase handshake, the FSM SHALL go to IDLE, clear the grant, pulse timeout_err for one cycle and load timeout_idx with grant_idx.
REQ-026 If a phase handshake and watchdog expiry occur in the same cycle, the handshake SHALL take precedence and timeout_err SHALL stay low.
REQ-027 After a timeout in round-robin mode, last_idx SHALL retain the timed-out master, so that master has lowest priority next.
REQ-028 Counter width SHALL be 16 bits; the counter SHALL saturate and never wrap.
REQ-029 Fixed-priority mode SHALL ignore last_idx; its logic may be optimised away.

Reset
REQ-030 With aresetn low at a clock edge, the FSM SHALL go to IDLE and grant_rd, grant_idx, grant_valid, timeout_err, timeout_idx and the counter SHALL go to 0.
REQ-031 Reset SHALL set last_idx to NUMBER_MASTER-1, so master 0 wins the first round-robin arbitration.
REQ-032 Reset asserted mid-transaction SHALL abort it without a timeout_err pulse.

Verification
REQ-033 RR, N=4, request_rd=4'b1111 held; complete each AR and R handshake in 1 cycle -> grants in order 0,1,2,3,0; grant_rd = 0001, 0010, 0100, 1000, 0001.
REQ-034 ARB_MODE=0, request_rd=4'b1010 held -> master 1 granted on every arbitration; master 3 is never granted.
REQ-035 Grant master 2, then drop request_rd[2] and raise request_rd[0] during DATA -> grant_rd stays 0100 until rvalid && rready[2], then 0 for one cycle, then 0001.
REQ-036 TIMEOUT_CYCLES=8; grant master 1 and never assert arready -> grant cleared after 8 ADDR cycles, timeout_err pulses once, timeout_idx=1, next RR winner is 2 if requesting.
REQ-037 TIMEOUT_CYCLES=8; rvalid && rready[granted] on exactly the 8th DATA cycle -> normal completion, timeout_err stays 0.
REQ-038 Assert aresetn low while in DATA -> next cycle all outputs 0 and FSM in IDLE; first grant after release goes to the lowest requesting index.
